// File: rtl/fifo_buffer_param.sv
// fifo_buffer_param: synchronous single-clock FIFO with occupancy count,
// almost-full/almost-empty thresholds and a one-cycle registered read port.
// Optional error tracking (sticky overflow/underflow) is compiled in by
// defining the macro FIFO_ERR_FLAGS_EN; without it both flags read as 0.
module fifo_buffer_param #(
  parameter int width            = 8,
  parameter int depth            = 4,
  parameter int almost_full_thr  = 2**depth - 2,
  parameter int almost_empty_thr = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             write,
  input  logic [width-1:0] w_data,
  input  logic             read,
  output logic [width-1:0] r_data,
  output logic             r_valid,
  output logic             empty,
  output logic             full,
  output logic             almost_empty,
  output logic             almost_full,
  output logic [depth:0]   count,
  output logic             overflow,
  output logic             underflow,
  input  logic             err_clr
);

  localparam int           CAP_INT = 1 << depth;
  localparam logic [depth:0] CAP   = CAP_INT[depth:0];
  localparam logic [depth:0] AF_THR = almost_full_thr[depth:0];
  localparam logic [depth:0] AE_THR = almost_empty_thr[depth:0];

  logic [width-1:0] mem [CAP_INT];
  logic [depth-1:0] w_ptr;
  logic [depth-1:0] r_ptr;
  logic             rd_ok;
  logic             wr_ok;

  // A read needs stored data; a write may use the slot a same-cycle read frees.
  always_comb begin
    rd_ok = read && !empty;
    wr_ok = write && (!full || rd_ok);
  end

  // Status flags come straight from the registered occupancy.
  always_comb begin
    empty        = (count == '0);
    full         = (count == CAP);
    almost_full  = (count >= AF_THR);
    almost_empty = (count <= AE_THR);
  end

  // Storage array; no reset so it maps to plain RAM, stale entries are unreachable.
  always_ff @(posedge clk) begin
    if (!reset && wr_ok) begin
      mem[w_ptr] <= w_data;
    end
  end

  // Pointers, occupancy and the registered read port.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_ptr   <= '0;
      r_ptr   <= '0;
      count   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= rd_ok;
      if (wr_ok) begin
        w_ptr <= w_ptr + depth'(1);
      end
      if (rd_ok) begin
        r_data <= mem[r_ptr];
        r_ptr  <= r_ptr + depth'(1);
      end
      if (wr_ok && !rd_ok) begin
        count <= count + (depth+1)'(1);
      end else if (rd_ok && !wr_ok) begin
        count <= count - (depth+1)'(1);
      end
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  // Sticky error flags; a new error event wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (write && !wr_ok) begin
        overflow <= 1'b1;
      end else if (err_clr) begin
        overflow <= 1'b0;
      end
      if (read && !rd_ok) begin
        underflow <= 1'b1;
      end else if (err_clr) begin
        underflow <= 1'b0;
      end
    end
  end
`else
  logic unused_err_clr;

  // Error tracking is compiled out: flags tie low and the clear input is ignored.
  always_comb begin
    overflow       = 1'b0;
    underflow      = 1'b0;
    unused_err_clr = err_clr;
  end
`endif

endmodule

// File: tb/tb_fifo_buffer_param.sv
// tb_fifo_buffer_param: directed plus short random stimulus for fifo_buffer_param
// (width=8, depth=2). A reference queue holds expected read data; occupancy
// and sticky flags come from a small behavioural model.
module tb_fifo_buffer_param;

  localparam int W   = 8;
  localparam int D   = 2;
  localparam int CAP = 1 << D;
  localparam int AF  = CAP - 2;
  localparam int AE  = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         write = 1'b0;
  logic [W-1:0] w_data = '0;
  logic         read = 1'b0;
  logic         err_clr = 1'b0;
  logic [W-1:0] r_data;
  logic         r_valid;
  logic         empty, full, almost_empty, almost_full;
  logic [D:0]   count;
  logic         overflow, underflow;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_q[$];
  int           m_count;
  logic         m_valid;
  logic [W-1:0] m_rdata;
  logic         m_ovf;
  logic         m_udf;

  fifo_buffer_param #(.width(W), .depth(D)) dut (
    .clk(clk), .reset(reset), .write(write), .w_data(w_data), .read(read),
    .r_data(r_data), .r_valid(r_valid), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full), .count(count),
    .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic checkOutput(input string step);
    check({step, ":count"}, 64'(count), 64'(m_count));
    check({step, ":empty"}, 64'(empty), 64'(m_count == 0));
    check({step, ":full"}, 64'(full), 64'(m_count == CAP));
    check({step, ":almost_full"}, 64'(almost_full), 64'(m_count >= AF));
    check({step, ":almost_empty"}, 64'(almost_empty), 64'(m_count <= AE));
    check({step, ":r_valid"}, 64'(r_valid), 64'(m_valid));
    check({step, ":r_data"}, 64'(r_data), 64'(m_rdata));
    check({step, ":overflow"}, 64'(overflow), 64'(m_ovf));
    check({step, ":underflow"}, 64'(underflow), 64'(m_udf));
  endtask

  // One clock of stimulus; model is updated from the pre-edge state.
  task automatic applyStimulus(input string step, input logic wr, input logic [W-1:0] wd,
                               input logic rd, input logic clr);
    logic rd_acc, wr_acc;
    rd_acc = rd && (m_count > 0);
    wr_acc = wr && ((m_count < CAP) || rd_acc);
    write = wr; w_data = wd; read = rd; err_clr = clr;
    m_valid = rd_acc;
    if (rd_acc) m_rdata = exp_q.pop_front();
    if (wr_acc) exp_q.push_back(wd);
    if (wr_acc && !rd_acc) m_count++;
    else if (rd_acc && !wr_acc) m_count--;
`ifdef FIFO_ERR_FLAGS_EN
    if (wr && !wr_acc) m_ovf = 1'b1; else if (clr) m_ovf = 1'b0;
    if (rd && !rd_acc) m_udf = 1'b1; else if (clr) m_udf = 1'b0;
`endif
    @(posedge clk);
    #1;
    write = 1'b0; read = 1'b0; err_clr = 1'b0;
    checkOutput(step);
  endtask

  task automatic applyReset(input string step, input logic wr, input logic rd);
    reset = 1'b1; write = wr; read = rd; w_data = 8'hEE;
    exp_q.delete();
    m_count = 0; m_valid = 1'b0; m_rdata = '0; m_ovf = 1'b0; m_udf = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0; write = 1'b0; read = 1'b0;
    checkOutput(step);
  endtask

  initial begin
    m_count = 0; m_valid = 1'b0; m_rdata = '0; m_ovf = 1'b0; m_udf = 1'b0;

    applyReset("reset", 1'b1, 1'b1);

    applyStimulus("wr11", 1, 8'h11, 0, 0);
    applyStimulus("wr22", 1, 8'h22, 0, 0);
    applyStimulus("wr33", 1, 8'h33, 0, 0);
    applyStimulus("wr44", 1, 8'h44, 0, 0);
    applyStimulus("wr55_full", 1, 8'h55, 0, 0);
    applyStimulus("wr56_full_clr", 1, 8'h56, 0, 1);
    for (int i = 0; i < 4; i++) applyStimulus("drain", 0, 8'h00, 1, 0);
    applyStimulus("idle_hold", 0, 8'h00, 0, 0);

    applyStimulus("rd_empty", 0, 8'h00, 1, 0);
    applyStimulus("err_clr", 0, 8'h00, 0, 1);
    applyStimulus("idle_cleared", 0, 8'h00, 0, 0);

    applyStimulus("empty_rw_a5", 1, 8'hA5, 1, 0);
    applyStimulus("rd_a5", 0, 8'h00, 1, 0);
    applyStimulus("idle_a5", 0, 8'h00, 0, 0);

    for (int i = 0; i < 4; i++) applyStimulus("fill", 1, W'(8'h60 + i), 0, 0);
    for (int i = 0; i < 6; i++) applyStimulus("full_rw", 1, W'(8'h66 + i), 1, 0);
    for (int i = 0; i < 5; i++) applyStimulus("drain_wrap", 0, 8'h00, 1, 0);
    applyStimulus("err_clr2", 0, 8'h00, 0, 1);

    for (int i = 0; i < 3; i++) applyStimulus("pre_reset", 1, W'(8'hC0 + i), 0, 0);
    applyReset("mid_reset", 1'b1, 1'b1);
    applyStimulus("wr77", 1, 8'h77, 0, 0);
    applyStimulus("rd77", 0, 8'h00, 1, 0);
    applyStimulus("rd_after77", 0, 8'h00, 1, 1);

    for (int i = 0; i < 60; i++)
      applyStimulus("random", 1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 7) == 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_buffer_param.md
FIFO_BUFFER_PARAM -- requirements
Module: fifo_buffer_param

Interface
REQ-001 Parameter width, default 8, data word width in bits (1..64).
REQ-002 Parameter depth, default 4, address width; capacity is 2**depth entries (depth 1..10).
REQ-003 Parameter almost_full_thr, default 2**depth-2, occupancy at or above which almost_full is asserted.
REQ-004 Parameter almost_empty_thr, default 2, occupancy at or below which almost_empty is asserted.
REQ-005 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 Port reset  input  1  reset, synchronous and active-high.
REQ-007 Port write  input  1  write request.
REQ-008 Port w_data  input  width  data written on an accepted write.
REQ-009 Port read  input  1  read request.
REQ-010 Port r_data  output  width  data of the most recently accepted read.
REQ-011 Port r_valid  output  1  single-cycle pulse marking r_data as fresh.
REQ-012 Port empty, full, almost_empty, almost_full  output  1 each  status flags.
REQ-013 Port count  output  depth+1  current occupancy, 0..2**depth.
REQ-014 Port overflow, underflow  output  1 each  sticky error flags.
REQ-015 Port err_clr  input  1  clears overflow and underflow.

Function
REQ-016 Storage is an internal 2**depth x width array; write pointer w_ptr and read pointer r_ptr are depth bits each and wrap from 2**depth-1 to 0.
REQ-017 A write is accepted when write=1 and (full=0 or an accepted read occurs in the same cycle).
REQ-018 A read is accepted when read=1 and empty=0; a read on an empty FIFO is never accepted, even with a simultaneous write.
REQ-019 Accepted write: mem[w_ptr] <= w_data, w_ptr increments.
REQ-020 Accepted read: r_data <= mem[r_ptr] on the same edge, r_ptr increments, r_valid = 1 in the following cycle only (read latency 1 cycle).
REQ-021 count: +1 for write only, -1 for read only, unchanged for both or neither; count never exceeds 2**depth nor goes below 0.
REQ-022 Full with read=1 and write=1: both accepted, count stays 2**depth, full stays 1.
REQ-023 Empty with read=1 and write=1: write only accepted, count becomes 1, r_valid stays 0.
REQ-024 Flags are combinational from registered count: empty = (count==0), full = (count==2**depth), almost_full = (count>=almost_full_thr), almost_empty = (count<=almost_empty_thr).
REQ-025 r_data holds its value until the next accepted read.
REQ-026 Data leaves in exactly the order written across any number of pointer wraps.

Reset
REQ-027 reset=1 at a rising edge sets w_ptr=0, r_ptr=0, count=0, r_data=0, r_valid=0, overflow=0, underflow=0; reset takes priority over all other inputs.
REQ-028 After reset: empty=1, full=0, almost_empty=1, almost_full=0 (for almost_full_thr>0).
REQ-029 Reset mid-operation discards all stored entries; array contents need not be cleared and are never readable before being rewritten.

Configuration
REQ-030 Macro FIFO_ERR_FLAGS_EN compiles in error tracking.
REQ-031 With FIFO_ERR_FLAGS_EN: overflow sets on write=1 not accepted; underflow sets on read=1 not accepted; both hold until err_clr=1 or reset; a set event and err_clr in the same cycle leave the flag set.
REQ-032 Without FIFO_ERR_FLAGS_EN: overflow and underflow are constant 0, err_clr is ignored, all other behaviour unchanged.

Verification (width=8, depth=2, thresholds default)
REQ-033 Reset, then write 0x11,0x22,0x33,0x44 -> count=4, full=1, almost_full=1 from count=2; four reads return 0x11..0x44 in order, each r_valid one cycle after its read.
REQ-034 Full FIFO, 5th write 0x55 -> rejected, count stays 4, overflow=1 (macro on) / 0 (macro off); next reads never return 0x55.
REQ-035 Empty FIFO, read=1 and write=1 with 0xA5 -> count=1, r_valid=0; next read returns 0xA5.
REQ-036 Full FIFO, read=1 and write=1 with 0x66 for 6 cycles -> count stays 4, pointers wrap, outputs stay in write order.
REQ-037 Empty FIFO read -> underflow=1 (macro on); err_clr pulse -> underflow=0.
REQ-038 Reset asserted with count=3 -> next cycle count=0, empty=1, r_valid=0, subsequent write/read returns the new data only.
